shift_arbiter: RTL and testbench

SHIFT_ARBITER -- requirements
Module: shift_arbiter

---
 rtl/shift_pkg.sv | 16 +
 rtl/shifter.sv | 23 ++
 rtl/shift_arbiter.sv | 110 +++++++++++
 tb/tb_shift_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared constants for the shift arbiter: datapath width, op encodings and FSM states.
package shift_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [1:0] SHIFT_SLL = 2'b00;
    localparam logic [1:0] SHIFT_ILL = 2'b01;
    localparam logic [1:0] SHIFT_SRL = 2'b10;
    localparam logic [1:0] SHIFT_SRA = 2'b11;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/shifter.sv
// Combinational barrel shifter: logical left/right and arithmetic right by 0..31.
module shifter
    import shift_pkg::*;
#(
    parameter int DATA_WIDTH = shift_pkg::DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [4:0]            B,
    input  logic [1:0]            Shiftop,
    output logic [DATA_WIDTH-1:0] Result
);

    always_comb begin
        Result = A;
        case (Shiftop)
            SHIFT_SLL: Result = A << B;
            SHIFT_SRL: Result = A >> B;
            SHIFT_SRA: Result = $signed(A) >>> B;
            default:   Result = A;
        endcase
    end

endmodule

// File: rtl/shift_arbiter.sv
// Two-requester round-robin front end sharing one shifter, with a single-entry
// result register that supports same-cycle drain and refill.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int DATA_WIDTH = shift_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [4:0]            req0_b,
    input  logic [1:0]            req0_op,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [4:0]            req1_b,
    input  logic [1:0]            req1_op,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_id,
    output logic                  rsp_err
);

    state_e                state_q, state_d;
    logic                  last_q, last_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  id_q, id_d;
    logic                  err_q, err_d;

    logic                  grant;
    logic                  can_accept;
    logic                  accept;
    logic [DATA_WIDTH-1:0] sel_a;
    logic [4:0]            sel_b;
    logic [1:0]            sel_op;
    logic                  sel_err;
    logic [DATA_WIDTH-1:0] shift_res;

    // Contention goes to whoever did not win the previous accept.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_q;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign can_accept = (state_q == ST_EMPTY) | rsp_ready;
    assign req0_ready = can_accept & req0_valid & ~grant;
    assign req1_ready = can_accept & req1_valid & grant;
    assign accept     = req0_ready | req1_ready;

    assign sel_a   = grant ? req1_a  : req0_a;
    assign sel_b   = grant ? req1_b  : req0_b;
    assign sel_op  = grant ? req1_op : req0_op;
    assign sel_err = (sel_op == SHIFT_ILL);

    shifter #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_shifter (
        .A      (sel_a),
        .B      (sel_b),
        .Shiftop(sel_op),
        .Result (shift_res)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        data_d  = data_q;
        id_d    = id_q;
        err_d   = err_q;
        if (accept) begin
            state_d = ST_FULL;
            last_d  = grant;
            data_d  = sel_err ? '0 : shift_res;
            id_d    = grant;
            err_d   = sel_err;
        end else if ((state_q == ST_FULL) && rsp_ready) begin
            state_d = ST_EMPTY;
        end
    end

    // last_q resets to 1 so the first contended grant goes to requester 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            last_q  <= 1'b1;
            data_q  <= '0;
            id_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            data_q  <= data_d;
            id_q    <= id_d;
            err_q   <= err_d;
        end
    end

    assign rsp_valid = (state_q == ST_FULL);
    assign rsp_data  = data_q;
    assign rsp_id    = id_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Randomized and directed bench for shift_arbiter against a behavioural model.
module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req1_a;
    logic [4:0]  req0_b, req1_b;
    logic [1:0]  req0_op, req1_op;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_id, rsp_err;

    int checks = 0;
    int failures = 0;

    // model state: is a result pending, its contents, and who won the last accept
    logic        m_full, m_id, m_err, m_last;
    logic [31:0] m_data;
    logic        c_g, c_can, c_e0, c_e1;
    logic        a0, a1;

    always #5 clk = ~clk;

    shift_arbiter #(.DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req0_op   (req0_op),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .req1_op   (req1_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_err   (rsp_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_shift(input logic [1:0] op, input logic [31:0] a,
                                                input logic [4:0] b);
        logic [31:0] fill;
        fill = a[31] ? ~(32'hFFFF_FFFF >> b) : 32'h0;
        case (op)
            2'b00:   return a << b;
            2'b10:   return a >> b;
            2'b11:   return (a >> b) | fill;
            default: return 32'h0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            m_full = 1'b0; m_id = 1'b0; m_err = 1'b0; m_last = 1'b1; m_data = 32'h0;
            chk("rst_valid", {31'b0, rsp_valid}, 32'h0);
            chk("rst_data", rsp_data, 32'h0);
            chk("rst_id", {31'b0, rsp_id}, 32'h0);
            chk("rst_err", {31'b0, rsp_err}, 32'h0);
        end else begin
            chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_full});
            if (m_full) begin
                chk("rsp_data", rsp_data, m_data);
                chk("rsp_id", {31'b0, rsp_id}, {31'b0, m_id});
                chk("rsp_err", {31'b0, rsp_err}, {31'b0, m_err});
            end
            c_g   = (req0_valid && req1_valid) ? ~m_last : (req1_valid && !req0_valid);
            c_can = !m_full || rsp_ready;
            c_e0  = c_can && req0_valid && !c_g;
            c_e1  = c_can && req1_valid && c_g;
            chk("req0_ready", {31'b0, req0_ready}, {31'b0, c_e0});
            chk("req1_ready", {31'b0, req1_ready}, {31'b0, c_e1});
            if (c_e0 || c_e1) begin
                m_full = 1'b1;
                m_last = c_g;
                m_id   = c_g;
                m_err  = c_g ? (req1_op == 2'b01) : (req0_op == 2'b01);
                m_data = c_g ? model_shift(req1_op, req1_a, req1_b)
                             : model_shift(req0_op, req0_a, req0_b);
            end else if (m_full && rsp_ready) begin
                m_full = 1'b0;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
        a0 = req0_valid & req0_ready;
        a1 = req1_valid & req1_ready;
        @(posedge clk);
        #2;
    endtask

    task automatic set0(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [4:0] b);
        req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    endtask

    task automatic set1(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [4:0] b);
        req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    endtask

    function automatic logic [4:0] pick_b();
        case ($urandom_range(0, 3))
            0:       return 5'd0;
            1:       return 5'd31;
            default: return 5'($urandom);
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        rsp_ready = 1'b0;
        a0 = 1'b0; a1 = 1'b0;
        set0(1'b0, 2'b00, 32'h0, 5'd0);
        set1(1'b0, 2'b00, 32'h0, 5'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", {31'b0, rsp_valid}, 32'h0);
        chk("reset_data", rsp_data, 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // single SRA from requester 0
        rsp_ready = 1'b1;
        set0(1'b1, 2'b11, 32'h8000_0001, 5'd4);
        tick();
        chk("sra_accept", {31'b0, a0}, 32'h1);
        chk("sra_valid", {31'b0, rsp_valid}, 32'h1);
        chk("sra_data", rsp_data, 32'hF800_0000);
        chk("sra_id", {31'b0, rsp_id}, 32'h0);
        chk("sra_err", {31'b0, rsp_err}, 32'h0);
        set0(1'b0, 2'b00, 32'h0, 5'd0);

        // illegal op from requester 1
        set1(1'b1, 2'b01, 32'hFFFF_FFFF, 5'd3);
        tick();
        chk("ill_accept", {31'b0, a1}, 32'h1);
        chk("ill_data", rsp_data, 32'h0);
        chk("ill_err", {31'b0, rsp_err}, 32'h1);
        chk("ill_id", {31'b0, rsp_id}, 32'h1);
        set1(1'b0, 2'b00, 32'h0, 5'd0);

        // boundary shift amounts
        set0(1'b1, 2'b11, 32'h8000_0000, 5'd0);
        tick();
        chk("sra_b0", rsp_data, 32'h8000_0000);
        set0(1'b1, 2'b11, 32'h8000_0000, 5'd31);
        tick();
        chk("sra_b31", rsp_data, 32'hFFFF_FFFF);
        set0(1'b0, 2'b00, 32'h0, 5'd0);
        set1(1'b1, 2'b00, 32'h0000_0001, 5'd31);
        tick();
        chk("sll_b31", rsp_data, 32'h8000_0000);

        // contention with consumer always ready: alternating back-to-back grants
        set0(1'b1, 2'b00, 32'h0000_0001, 5'd8);
        set1(1'b1, 2'b10, 32'hF000_0000, 5'd4);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr_grant0", {31'b0, a0}, (i % 2 == 0) ? 32'h1 : 32'h0);
            chk("rr_grant1", {31'b0, a1}, (i % 2 == 1) ? 32'h1 : 32'h0);
            chk("rr_valid", {31'b0, rsp_valid}, 32'h1);
            chk("rr_id", {31'b0, rsp_id}, (i % 2 == 1) ? 32'h1 : 32'h0);
            chk("rr_data", rsp_data, (i % 2 == 1) ? 32'h0F00_0000 : 32'h0000_0100);
        end

        // consumer stalls while full with both requesters waiting
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_r0", {31'b0, a0}, 32'h0);
            chk("stall_r1", {31'b0, a1}, 32'h0);
            chk("stall_data", rsp_data, 32'h0F00_0000);
            chk("stall_valid", {31'b0, rsp_valid}, 32'h1);
        end
        rsp_ready = 1'b1;
        tick();
        chk("resume_acc", {31'b0, a0}, 32'h1);
        chk("resume_data", rsp_data, 32'h0000_0100);
        chk("resume_id", {31'b0, rsp_id}, 32'h0);

        // asynchronous reset with a result pending
        rsp_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_valid", {31'b0, rsp_valid}, 32'h0);
        chk("async_data", rsp_data, 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        tick();
        chk("post_rst_g0", {31'b0, a0}, 32'h1);
        chk("post_rst_g1", {31'b0, a1}, 32'h0);
        chk("post_rst_id", {31'b0, rsp_id}, 32'h0);
        tick();
        chk("post_rst_next", {31'b0, a1}, 32'h1);

        // randomized traffic; requesters hold until accepted
        for (int n = 0; n < 600; n++) begin
            rsp_ready = ($urandom_range(0, 9) < 7);
            if (!req0_valid || a0)
                set0($urandom_range(0, 2) != 0, 2'($urandom), $urandom, pick_b());
            if (!req1_valid || a1)
                set1($urandom_range(0, 2) != 0, 2'($urandom), $urandom, pick_b());
            tick();
        end

        set0(1'b0, 2'b00, 32'h0, 5'd0);
        set1(1'b0, 2'b00, 32'h0, 5'd0);
        rsp_ready = 1'b1;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
